// File: rtl/rng_request_arbiter.sv
// Round-robin front end that shares one external XNOR LFSR between requesters and
// turns its raw state into bounded results by masked rejection sampling.
`timescale 1ns/1ps
module rng_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BITS  = 8,
  parameter int WARMUP    = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*NUM_BITS-1:0]  limit_i,
  input  logic                         reseed_i,
  input  logic [NUM_BITS-1:0]          seed_val_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_BITS-1:0]          rnd_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         lfsr_en_o,
  output logic                         lfsr_seed_o,
  output logic [NUM_BITS-1:0]          lfsr_seed_data_o,
  input  logic [NUM_BITS-1:0]          lfsr_data_i
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WARM_W = $clog2(WARMUP + 2);
  localparam int TRY_W  = $clog2(MAX_TRIES + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_WARM  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [NUM_BITS-1:0] ONE_B     = NUM_BITS'(1);
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [TRY_W-1:0]    TRY_MAX   = TRY_W'(MAX_TRIES);

  // Smallest 2^k-1 covering lim-1, built by smearing the top set bit downward.
  function automatic logic [NUM_BITS-1:0] range_mask(input logic [NUM_BITS-1:0] lim);
    logic [NUM_BITS-1:0] m;
    m = lim - ONE_B;
    for (int s = 1; s < NUM_BITS; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  // All-ones is the XNOR lockup state.
  function automatic logic [NUM_BITS-1:0] sanitize(input logic [NUM_BITS-1:0] seed);
    return (&seed) ? {NUM_BITS{1'b0}} : seed;
  endfunction

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, rr_q, rr_d, pick_s;
  logic [NUM_BITS-1:0] lim_q, lim_d, cnt_q, cap_q, seed_s, res_s, cand_s;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                seeded_q, seeded_d, pend_q, found_s;
  logic [NUM_REQ-1:0]  gnt_s;

  logic                en_q, seed_q, busy_q, valid_q;
  logic [NUM_BITS-1:0] seed_data_q, rnd_q;
  logic [NUM_REQ-1:0]  gnt_q;

  // Circular search for the first active request at or after rr_q.
  always_comb begin
    int j;
    pick_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      else              j = j;
      if (!found_s && req_i[j]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lim_d    = lim_q;
    tries_d  = tries_q;
    warm_d   = warm_q;
    seeded_d = seeded_q;
    rr_d     = rr_q;
    seed_s   = seed_data_q;
    res_s    = rnd_q;
    cand_s   = lfsr_data_i & range_mask(lim_q);
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          seed_s  = sanitize(cap_q);
          state_d = S_SEED;
        end else if (found_s && !seeded_q) begin
          seed_s  = sanitize(cnt_q);
          state_d = S_SEED;
        end else if (found_s) begin
          idx_d   = pick_s;
          lim_d   = limit_i[int'(pick_s)*NUM_BITS +: NUM_BITS];
          tries_d = '0;
          state_d = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEED: begin
        seeded_d = 1'b1;
        warm_d   = '0;
        if (WARMUP == 0) state_d = S_IDLE;
        else             state_d = S_WARM;
      end
      S_WARM: begin
        if (warm_q == WARM_LAST) begin
          state_d = S_IDLE;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      S_STEP: state_d = S_CHECK;
      S_CHECK: begin
        if (lim_q == '0) begin
          res_s   = lfsr_data_i;
          state_d = S_DONE;
        end else if (cand_s < lim_q) begin
          res_s   = cand_s;
          state_d = S_DONE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          if (tries_d == TRY_MAX) begin
            res_s   = cand_s - lim_q;
            state_d = S_DONE;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_DONE: begin
        if (idx_q == IDX_W'(NUM_REQ - 1)) rr_d = '0;
        else                              rr_d = idx_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    gnt_s = '0;
    if (state_d == S_DONE) gnt_s[idx_q] = 1'b1;
    else                   gnt_s = '0;
  end

  // Control state, counters and the reseed latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rr_q     <= '0;
      lim_q    <= '0;
      tries_q  <= '0;
      warm_q   <= '0;
      seeded_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      lim_q    <= lim_d;
      tries_q  <= tries_d;
      warm_q   <= warm_d;
      seeded_q <= seeded_d;
      cnt_q    <= cnt_q + ONE_B;
      // A pulse arriving during SEED stays pending so the newest seed still applies.
      if (reseed_i) begin
        pend_q <= 1'b1;
        cap_q  <= seed_val_i;
      end else if (state_q == S_SEED) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_q;
      end
    end
  end

  // Outputs registered from the next state so they align with the state they decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b0;
      seed_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      gnt_q       <= '0;
      seed_data_q <= '0;
      rnd_q       <= '0;
    end else begin
      en_q        <= (state_d == S_SEED) || (state_d == S_WARM) || (state_d == S_STEP);
      seed_q      <= (state_d == S_SEED);
      busy_q      <= (state_d != S_IDLE);
      valid_q     <= (state_d == S_DONE);
      gnt_q       <= gnt_s;
      seed_data_q <= seed_s;
      if (state_d == S_DONE) rnd_q <= res_s;
      else                   rnd_q <= rnd_q;
    end
  end

  assign gnt_o            = gnt_q;
  assign rnd_o            = rnd_q;
  assign valid_o          = valid_q;
  assign busy_o           = busy_q;
  assign lfsr_en_o        = en_q;
  assign lfsr_seed_o      = seed_q;
  assign lfsr_seed_data_o = seed_data_q;

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench for rng_request_arbiter with a behavioural XNOR LFSR and a
// software model of seeding, warm-up and rejection sampling.
`timescale 1ns/1ps
module tb_rng_request_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [31:0] limit_i;
  logic        reseed_i;
  logic [7:0]  seed_val_i;
  logic [3:0]  gnt_o;
  logic [7:0]  rnd_o;
  logic        valid_o, busy_o, lfsr_en_o, lfsr_seed_o;
  logic [7:0]  lfsr_seed_data_o, lfsr_data_i;

  logic [7:0]  lfsr_q = 8'h00;
  logic        force_ff = 1'b0;
  logic [7:0]  cnt_m;
  logic [7:0]  msoft;
  int          checks = 0;
  int          failures = 0;
  int          mptr = 0;

  always #5 clk = ~clk;

  rng_request_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .limit_i(limit_i),
    .reseed_i(reseed_i), .seed_val_i(seed_val_i), .gnt_o(gnt_o), .rnd_o(rnd_o),
    .valid_o(valid_o), .busy_o(busy_o), .lfsr_en_o(lfsr_en_o), .lfsr_seed_o(lfsr_seed_o),
    .lfsr_seed_data_o(lfsr_seed_data_o), .lfsr_data_i(lfsr_data_i)
  );

  function automatic logic [7:0] step8(input logic [7:0] q);
    return {q[6:0], ~(q[7] ^ q[5] ^ q[4] ^ q[3])};
  endfunction

  function automatic logic [7:0] warm(input logic [7:0] s);
    logic [7:0] q;
    q = s;
    for (int k = 0; k < 4; k++) q = step8(q);
    return q;
  endfunction

  function automatic logic [7:0] mdl_mask(input logic [7:0] lim);
    int lm1;
    lm1 = int'(lim) - 1;
    for (int k = 0; k <= 8; k++) begin
      if ((1 << k) - 1 >= lm1) return 8'((1 << k) - 1);
    end
    return 8'hFF;
  endfunction

  // External LFSR the arbiter controls.
  always @(posedge clk) begin
    if (lfsr_en_o) lfsr_q <= lfsr_seed_o ? lfsr_seed_data_o : step8(lfsr_q);
  end
  assign lfsr_data_i = force_ff ? 8'hFF : lfsr_q;

  // Reference free-running counter.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cnt_m <= 8'h00;
    else         cnt_m <= cnt_m + 8'h01;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_limit(input int idx, input logic [7:0] lim);
    limit_i[idx*8 +: 8] = lim;
  endtask

  // Called at the negedge before SEED; returns at the negedge of the post-warm IDLE cycle.
  task automatic seed_phase(input bit use_cnt, input logic [7:0] val);
    logic [7:0] exp;
    @(negedge clk);
    exp = use_cnt ? 8'(cnt_m - 8'h01) : val;
    if (exp == 8'hFF) exp = 8'h00;
    chk("seed_pulse", {lfsr_seed_o, lfsr_en_o, valid_o}, 32'h6);
    chk("seed_data", lfsr_seed_data_o, exp);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("warm_en", {lfsr_en_o, lfsr_seed_o}, 32'h2);
    end
    @(negedge clk);
    chk("post_warm_idle", {busy_o, lfsr_en_o}, 32'h0);
    msoft = warm(exp);
  endtask

  // Called at the selecting IDLE negedge (pre cycles already elapsed); returns at DONE negedge.
  task automatic finish_req(input int idx, input logic [7:0] lim, input int pre,
                            output logic [7:0] got);
    logic [7:0] v, cand, exp_v;
    logic [3:0] oh;
    int nchk, n;
    bit done;
    nchk = 0; done = 0; exp_v = 8'h00;
    while (!done) begin
      msoft = step8(msoft);
      v = force_ff ? 8'hFF : msoft;
      nchk++;
      if (lim == 8'h00) begin
        exp_v = v; done = 1;
      end else begin
        cand = v & mdl_mask(lim);
        if (cand < lim) begin
          exp_v = cand; done = 1;
        end else if (nchk == 8) begin
          exp_v = cand - lim; done = 1;
        end
      end
    end
    n = pre;
    do begin
      @(negedge clk);
      n++;
    end while (valid_o !== 1'b1 && n < 60);
    oh = 4'b0001;
    oh = oh << idx;
    chk("valid", valid_o, 1);
    chk("latency", n, 2 * nchk + 1);
    chk("gnt", gnt_o, oh);
    chk("rnd", rnd_o, exp_v);
    if (lim != 8'h00) chk("in_range", rnd_o < lim, 1);
    got = rnd_o;
    mptr = (idx + 1) % 4;
  endtask

  task automatic run_req(input int idx, input logic [7:0] lim, output logic [7:0] got);
    req_i = 4'b0000;
    req_i[idx] = 1'b1;
    set_limit(idx, lim);
    finish_req(idx, lim, 0, got);
    req_i = 4'b0000;
    @(negedge clk);
    chk("rnd_hold", {valid_o, rnd_o}, {24'h0, 1'b0, got});
  endtask

  task automatic do_reseed(input logic [7:0] val);
    reseed_i = 1'b1;
    seed_val_i = val;
    @(negedge clk);
    reseed_i = 1'b0;
    seed_val_i = 8'h00;
    seed_phase(0, val);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] seq_a [6];
    bit saw_valid;
    rst_ni = 1'b1; req_i = 4'b0000; limit_i = 32'h0; reseed_i = 1'b0; seed_val_i = 8'h00;
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt_o, rnd_o, valid_o, busy_o, lfsr_en_o, lfsr_seed_o, lfsr_seed_data_o}, 32'h0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);

    // First request auto-seeds from the counter.
    req_i = 4'b0001; set_limit(0, 8'd10);
    seed_phase(1, 8'h00);
    finish_req(0, 8'd10, 0, got);
    req_i = 4'b0000;
    @(negedge clk);

    // Round-robin with all requests held and full-range limits.
    do_reseed(8'hC3);
    limit_i = 32'h0;
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      finish_req(mptr, 8'h00, 0, got);
      @(negedge clk);
      chk("rr_idle_gap", {busy_o, valid_o, rnd_o}, {22'h0, 2'b00, got});
    end
    req_i = 4'b0000;
    @(negedge clk);

    // Reseed determinism.
    do_reseed(8'h5A);
    for (int k = 0; k < 6; k++) run_req(2, 8'd37, seq_a[k]);
    do_reseed(8'h5A);
    for (int k = 0; k < 6; k++) begin
      run_req(2, 8'd37, got);
      chk("determinism", got, seq_a[k]);
    end
    do_reseed(8'hFF);

    // limit 1 always yields 0.
    for (int k = 0; k < 3; k++) begin
      run_req(1, 8'd1, got);
      chk("lim1_zero", got, 8'h00);
    end

    // Fallback after MAX_TRIES rejections.
    force_ff = 1'b1;
    run_req(0, 8'd129, got);
    force_ff = 1'b0;
    chk("fallback_val", got, 8'd126);

    // Reseed during CHECK is deferred until the current result completes.
    req_i = 4'b1000; set_limit(3, 8'h00); set_limit(0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reseed_i = 1'b1; seed_val_i = 8'h33;
    fork
      begin @(negedge clk); reseed_i = 1'b0; seed_val_i = 8'h00; end
    join_none
    finish_req(3, 8'h00, 2, got);
    req_i = 4'b0001;
    @(negedge clk);
    chk("defer_idle", {busy_o, valid_o, lfsr_seed_o}, 32'h0);
    seed_phase(0, 8'h33);
    finish_req(0, 8'h00, 0, got);
    req_i = 4'b0000;
    @(negedge clk);

    // Asynchronous reset while in CHECK.
    req_i = 4'b0010; set_limit(1, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_check", busy_o, 1);
    rst_ni = 1'b0;
    req_i = 4'b0000;
    #1;
    chk("mid_reset_outputs", {gnt_o, rnd_o, valid_o, busy_o, lfsr_en_o, lfsr_seed_o, lfsr_seed_data_o}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    saw_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) saw_valid = 1;
    end
    chk("no_valid_after_reset", saw_valid, 0);
    req_i = 4'b0010; set_limit(1, 8'd5);
    seed_phase(1, 8'h00);
    finish_req(1, 8'd5, 0, got);
    req_i = 4'b0000;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
